// File: rtl/ram_access_ctrl_if.sv
// ram_access_ctrl_if: client handshakes and storage pins of the single-word storage controller.
// Latency: none (wires only).
// Backpressure: none here; each client holds req until its ack pulse.
// Signals: req/we/wdata/ack per client A and B, shared rdata and busy,
//          storage strobes ram_ce/ram_we/ram_di and storage read data ram_do.
interface ram_access_ctrl_if #(
  parameter int DW = 32
);
  logic          req_a;
  logic          we_a;
  logic [DW-1:0] wdata_a;
  logic          ack_a;
  logic          req_b;
  logic          we_b;
  logic [DW-1:0] wdata_b;
  logic          ack_b;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          ram_ce;
  logic          ram_we;
  logic [DW-1:0] ram_di;
  logic [DW-1:0] ram_do;

  // The controller initiates every storage access.
  modport master (
    input  req_a, we_a, wdata_a, req_b, we_b, wdata_b, ram_do,
    output ack_a, ack_b, rdata, busy, ram_ce, ram_we, ram_di
  );

  // Clients and the storage word sit on this side.
  modport slave (
    output req_a, we_a, wdata_a, req_b, we_b, wdata_b, ram_do,
    input  ack_a, ack_b, rdata, busy, ram_ce, ram_we, ram_di
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: round-robin arbiter and strobe sequencer for the single-word storage register.
// Latency: req sampled at edge k -> storage strobe during cycle k+1 -> ack and rdata at edge k+2.
// Backpressure: one access at a time; a losing client holds req and is served next.
// Ports: clk, rst (async, active-high); bus (master modport) carries client req/we/wdata/ack,
//        the shared rdata/busy outputs and the storage pins ram_ce/ram_we/ram_di/ram_do.
module ram_access_ctrl #(
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  ram_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          start;
  logic          win_b;
  logic          win_we;
  logic [DW-1:0] win_wdata;

  logic          op_b;
  logic          op_we;
  logic [DW-1:0] op_wdata;
  logic          last_b;

  logic          ce_q;
  logic          we_q;
  logic          ack_a_q;
  logic          ack_b_q;
  logic [DW-1:0] rdata_q;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    // On a tie the client that was not granted last wins.
    win_b     = bus.req_b & (~bus.req_a | ~last_b);
    win_we    = win_b ? bus.we_b : bus.we_a;
    win_wdata = win_b ? bus.wdata_b : bus.wdata_a;
    case (state)
      IDLE: begin
        if (bus.req_a | bus.req_b) begin
          start     = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_b     <= 1'b0;
      op_we    <= 1'b0;
      op_wdata <= '0;
      last_b   <= 1'b1;
      ce_q     <= 1'b0;
      we_q     <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      rdata_q  <= '0;
    end else begin
      // Operation fields are frozen at grant; later client changes are ignored.
      if (start) begin
        op_b     <= win_b;
        op_we    <= win_we;
        op_wdata <= win_wdata;
      end
      if (state == DONE) begin
        last_b <= op_b;
      end
      // Strobes are registered so they are high exactly for the ACCESS cycle.
      ce_q    <= start;
      we_q    <= start & win_we;
      ack_a_q <= (state == ACCESS) & ~op_b;
      ack_b_q <= (state == ACCESS) & op_b;
      // ram_do is only meaningful while ce is high; a write reads back the new word.
      if (ce_q) begin
        rdata_q <= bus.ram_do;
      end
    end
  end

  assign bus.ram_ce = ce_q;
  assign bus.ram_we = we_q;
  assign bus.ram_di = op_wdata;
  assign bus.ack_a  = ack_a_q;
  assign bus.ack_b  = ack_b_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = (state != IDLE);

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Initiator for the calculator's single-word 32-bit storage register, which samples CE/WE/Di on the falling clock edge and drives its read port combinationally while CE is high. The block arbitrates between two clients, A (operand entry) and B (ALU write-back), and sequences one access at a time. It generates the CE/WE/Di strobes and captures the read-port data. Each client sees a simple req/ack handshake and never touches the storage pins directly.

## Interface
Parameters:
- DW, 32, data width of the storage word and all data ports

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req_a  input  1  client A access request, held until ack_a
- we_a  input  1  client A: 1 = write, 0 = read; stable while req_a high
- wdata_a  input  DW  client A write data; stable while req_a high
- req_b, we_b, wdata_b  input  1/1/DW  same for client B
- ack_a  output  1  one-cycle completion pulse to A
- ack_b  output  1  one-cycle completion pulse to B
- rdata  output  DW  captured storage word, valid with and after ack_x until next capture
- busy  output  1  high in any state other than IDLE
- ram_ce  output  1  storage chip enable
- ram_we  output  1  storage write enable
- ram_di  output  DW  storage write data
- ram_do  input  DW  storage read data (high-Z when ram_ce low)

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset state IDLE.
- IDLE: no req -> stay. Any req -> latch winner id, we and wdata into op registers; go ACCESS.
- Arbitration: one requester -> it wins. Both -> the client not granted last wins (round-robin). Reset sets last_grant = B, so A wins the first tie.
- ACCESS (exactly 1 cycle): ram_ce=1, ram_we=op_we, ram_di=op_wdata. Storage writes on the falling edge inside this cycle. At the closing rising edge, rdata <= ram_do for both reads and writes, so a write returns the written value as read-back. Go DONE.
- DONE (1 cycle): ram_ce=0, ram_we=0; ack of the granted client = 1; last_grant <= granted id; go IDLE.
- ram_di holds op_wdata outside ACCESS. ram_ce/ram_we are registered and never high outside ACCESS.
- Client rule: deassert req in the cycle after ack. A req still high in the IDLE cycle after DONE is a new request. A loser's req is held and served next.
- ram_do is sampled only while ram_ce=1. The high-Z value is never captured.
- Reset values: ack_a=ack_b=0, busy=0, ram_ce=0, ram_we=0, ram_di=0, rdata=0, op registers 0.

## Timing
- req_x high at rising edge k (FSM in IDLE): ACCESS during cycle k+1, ack_x high during cycle k+2, rdata valid from edge k+2.
- Latency 2 cycles from sampled req to ack. Maximum rate is one access per 3 cycles per port.
- Both requests continuous: grants alternate A, B, A, ... with a 3-cycle period each.
- we_x/wdata_x are sampled only at the IDLE->ACCESS edge. Later changes are ignored for that access.
- Reset asserted mid-ACCESS:
  - Outputs drop immediately and no ack is issued.
  - If the reset precedes the ACCESS falling edge, the write is lost.
  - If it follows, the write completes.
  - In either case the client reissues the request.
- Reset during DONE: the ack pulse is truncated. The client treats the access as not acknowledged.

## Test plan
- Reset, then A write 0xDEADBEEF: ram_ce=ram_we=1 for exactly one cycle; ack_a one cycle later; rdata=0xDEADBEEF; busy high for 2 cycles.
- A read after that write: ram_we=0 in ACCESS; rdata=0xDEADBEEF with ack_a; storage unchanged.
- req_a and req_b raised on the same edge (A writes 0x1, B writes 0x2): A is served first with ack_a, then B; final rdata=0x2; ack_b 3 cycles after ack_a.
- Both requests held continuously for 12 cycles: ack pattern A,B,A,B, one ack every 3 cycles, never both acks in one cycle.
- Change wdata_a to 0x55 during ACCESS of a write of 0xAA: storage and rdata = 0xAA.
- Assert rst for half a cycle during ACCESS: ram_ce falls immediately, no ack, FSM in IDLE with all outputs at reset values; a reissued request completes normally.
